// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60Hz timing generator (pixel divider, h/v counters, sync/bright decode).
// Optional `VGA_FRAME_CNT_EN adds a 16-bit frame_count output.
`timescale 1ns/1ps
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;

  localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // 11-bit bounds so a display window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_DISP_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_DISP_END = 11'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] V_DISP_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_DISP_END = 11'(V_SYNC + V_BACK + V_DISPLAY);

  logic [3:0]  r_div;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_bright;
  logic        r_frame_tick;

  logic        w_pix_en;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_wrap;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;

  assign w_pix_en     = (r_div == DIV_LAST);
  assign w_h_last     = (r_h == H_LAST);
  assign w_v_last     = (r_v == V_LAST);
  assign w_frame_wrap = w_pix_en & w_h_last & w_v_last;

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_pix_en) begin
      if (w_h_last) begin
        w_h_next = '0;
        w_v_next = w_v_last ? '0 : r_v + 10'd1;
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
  end

  assign w_h_ext = {1'b0, w_h_next};
  assign w_v_ext = {1'b0, w_v_next};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  // Decodes use next-state counts so sync/bright land on the same edge as the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h          <= '0;
      r_v          <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_bright     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_h          <= w_h_next;
      r_v          <= w_v_next;
      r_hsync      <= ~(w_h_ext < H_SYNC_END);
      r_vsync      <= ~(w_v_ext < V_SYNC_END);
      r_bright     <= (w_h_ext >= H_DISP_BEG) && (w_h_ext < H_DISP_END) &&
                      (w_v_ext >= V_DISP_BEG) && (w_v_ext < V_DISP_END);
      r_frame_tick <= w_frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (w_frame_wrap) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign hCount     = r_h;
  assign vCount     = r_v;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign bright     = r_bright;
  assign pix_en     = w_pix_en;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen: default-timing instance plus a shrunken-timing instance.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int D1_DIV = 3;
  localparam int D1_HS = 3, D1_HB = 2, D1_HD = 6, D1_HF = 2;
  localparam int D1_VS = 2, D1_VB = 1, D1_VD = 4, D1_VF = 2;
  localparam int D1_FRAME = D1_DIV * (D1_HS + D1_HB + D1_HD + D1_HF) * (D1_VS + D1_VB + D1_VD + D1_VF);

  logic clk = 1'b0;
  logic rst0_n, rst1_n;

  logic [9:0] h0, v0, h1, v1;
  logic       hs0, vs0, br0, pe0, ft0;
  logic       hs1, vs1, br1, pe1, ft1;
  logic [15:0] fc0, fc1;

  int n_tests = 0;
  int n_fail  = 0;
  int n0 = 0;
  int n1 = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut0 (
    .clk(clk), .reset_n(rst0_n), .hCount(h0), .vCount(v0), .hSync(hs0), .vSync(vs0),
    .bright(br0), .pix_en(pe0), .frame_tick(ft0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc0)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(D1_DIV), .H_SYNC(D1_HS), .H_BACK(D1_HB), .H_DISPLAY(D1_HD), .H_FRONT(D1_HF),
    .V_SYNC(D1_VS), .V_BACK(D1_VB), .V_DISPLAY(D1_VD), .V_FRONT(D1_VF)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .hCount(h1), .vCount(v1), .hSync(hs1), .vSync(vs1),
    .bright(br1), .pix_en(pe1), .frame_tick(ft1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc1)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
`endif

  typedef struct {
    int h; int v; bit hs; bit vs; bit br; bit pe; bit ft; int fc;
  } exp_t;

  typedef struct {
    int n; int h; int v; bit hs; bit vs; bit br; bit pe; bit ft;
  } vec_t;

  // Reference: position is pure arithmetic on the number of clock edges since reset release
  function automatic exp_t model(int n, int div, int hs, int hb, int hd, int hf,
                                 int vs, int vb, int vd, int vf);
    exp_t e;
    int ht = hs + hb + hd + hf;
    int vt = vs + vb + vd + vf;
    int p  = n / div;
    e.h  = p % ht;
    e.v  = (p / ht) % vt;
    e.hs = (e.h >= hs);
    e.vs = (e.v >= vs);
    e.br = (e.h >= hs + hb) && (e.h < hs + hb + hd) && (e.v >= vs + vb) && (e.v < vs + vb + vd);
    e.pe = ((n % div) == div - 1);
    e.ft = (p > 0) && ((p % (ht * vt)) == 0) && ((n % div) == 0);
    e.fc = (p / (ht * vt)) % 65536;
    return e;
  endfunction

  function automatic exp_t model0(int n);
    return model(n, 4, 96, 48, 640, 16, 2, 33, 480, 10);
  endfunction

  function automatic exp_t model1(int n);
    return model(n, D1_DIV, D1_HS, D1_HB, D1_HD, D1_HF, D1_VS, D1_VB, D1_VD, D1_VF);
  endfunction

  function automatic logic [24:0] pack_exp(exp_t e);
    return {10'(e.h), 10'(e.v), e.hs, e.vs, e.br, e.pe, e.ft};
  endfunction

  function automatic logic [24:0] act0();
    return {h0, v0, hs0, vs0, br0, pe0, ft0};
  endfunction

  function automatic logic [24:0] act1();
    return {h1, v1, hs1, vs1, br1, pe1, ft1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[11];
  exp_t e;
  int cnt_hs_low, cnt_br, cnt_vs_low, cnt_ft;
  int len, hold;

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    vecs[0]  = '{0,    0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{3,    0,   0, 0, 0, 0, 1, 0};
    vecs[2]  = '{4,    1,   0, 0, 0, 0, 0, 0};
    vecs[3]  = '{383,  95,  0, 0, 0, 0, 1, 0};
    vecs[4]  = '{384,  96,  0, 1, 0, 0, 0, 0};
    vecs[5]  = '{576,  144, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{3136, 784, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{3199, 799, 0, 1, 0, 0, 1, 0};
    vecs[8]  = '{3200, 0,   1, 0, 0, 0, 0, 0};
    vecs[9]  = '{6400, 0,   2, 0, 1, 0, 0, 0};
    vecs[10] = '{6976, 144, 2, 1, 1, 0, 0, 0};

    // Reset held 5 clocks: everything reads zero
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", act0(), 25'd0);
      check("reset_hold_fc", 32'(fc0), 32'd0);
    end
    rst0_n = 1'b1;
    n0 = 0;

    // Default timing: hand-computed table walked in increasing edge order
    for (int i = 0; i < 11; i++) begin
      while (n0 < vecs[i].n) begin
        step();
        n0++;
      end
      check($sformatf("table[%0d]", i), act0(),
            {10'(vecs[i].h), 10'(vecs[i].v), vecs[i].hs, vecs[i].vs, vecs[i].br, vecs[i].pe, vecs[i].ft});
    end

    // One full line: hSync low for 96 pixels = 384 clocks, every sample matches the model
    rst0_n = 1'b0;
    step();
    rst0_n = 1'b1;
    n0 = 0;
    cnt_hs_low = 0;
    while (n0 < 3200) begin
      if (!hs0) cnt_hs_low++;
      check("line_model", act0(), pack_exp(model0(n0)));
      step();
      n0++;
    end
    check("hsync_low_clks", 32'(cnt_hs_low), 32'd384);

    // Mid-line reset at hCount=500, vCount=1: clears with no clock edge, then restarts cleanly
    while (n0 < 5200) begin
      step();
      n0++;
    end
    check("pre_reset_pos", {22'd0, h0}, 32'd500);
    #2;
    rst0_n = 1'b0;
    #1;
    check("async_clear", act0(), 25'd0);
    step();
    step();
    rst0_n = 1'b1;
    n0 = 0;
    while (n0 < 13) begin
      check("restart_model", act0(), pack_exp(model0(n0)));
      step();
      n0++;
    end
    rst0_n = 1'b0;

    // Small-timing instance: frame-level totals
    step();
    rst1_n = 1'b1;
    n1 = 0;
    cnt_br = 0;
    cnt_vs_low = 0;
    cnt_ft = 0;
    while (n1 <= 2 * D1_FRAME) begin
      if (n1 < D1_FRAME) begin
        if (br1) cnt_br++;
        if (!vs1) cnt_vs_low++;
      end
      if (ft1) begin
        cnt_ft++;
        check("tick_at_origin", {12'd0, h1, v1}, 32'd0);
      end
      step();
      n1++;
    end
    check("bright_clks", 32'(cnt_br), 32'd72);
    check("vsync_low_clks", 32'(cnt_vs_low), 32'd78);
    check("tick_count", 32'(cnt_ft), 32'd2);
`ifdef VGA_FRAME_CNT_EN
    while (n1 < 3 * D1_FRAME + 1) begin
      step();
      n1++;
    end
    check("frame_count_3", 32'(fc1), 32'd3);
`endif

    // Randomized run lengths and asynchronous resets against the arithmetic model
    for (int it = 0; it < 25; it++) begin
      rst1_n = 1'b0;
      #($urandom_range(1, 3));
      #1;
      check("rand_async_clear", act1(), 25'd0);
      hold = $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) begin
        step();
        check("rand_reset_hold", act1(), 25'd0);
      end
      rst1_n = 1'b1;
      n1 = 0;
      len = $urandom_range(1, 900);
      for (int k = 0; k < len; k++) begin
        e = model1(n1);
        check("rand_model", act1(), pack_exp(e));
`ifdef VGA_FRAME_CNT_EN
        check("rand_frame_count", 32'(fc1), 32'(e.fc));
`endif
        step();
        n1++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
